// File: rtl/mul_seq_pkg.sv
// Shared definitions for the mul_seq shift-add multiplier: ALU opcodes, FSM state codes, widths.
package mul_seq_pkg;

    localparam int unsigned DW  = 16;
    localparam int unsigned CW  = 4;
    localparam int unsigned OPW = 6;

    // ALU control word, MSB first: zero x, negate x, zero y, negate y, add/and, negate out
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctl_t;

    localparam logic [OPW-1:0] OP_ZERO = 6'b101010;
    localparam logic [OPW-1:0] OP_X    = 6'b001100;
    localparam logic [OPW-1:0] OP_ADD  = 6'b000010;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DBL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/mul_seq_alu16.sv
// Alu16: combinational 16-bit ALU with a single adder, driven by a 6-bit control word.
module alu16
    import mul_seq_pkg::*;
(
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    input  alu_ctl_t      ctl,
    output logic [DW-1:0] res_c,
    output logic          zr_c,
    output logic          ng_c
);

    logic [DW-1:0] xz, xn, yz, yn, fo;

    always_comb begin
        xz    = ctl.zx ? '0 : x;
        xn    = ctl.nx ? ~xz : xz;
        yz    = ctl.zy ? '0 : y;
        yn    = ctl.ny ? ~yz : yz;
        fo    = ctl.f ? DW'(xn + yn) : (xn & yn);
        res_c = ctl.no ? ~fo : fo;
        zr_c  = (res_c == '0);
        ng_c  = res_c[DW-1];
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential 16x16 shift-add multiplier (low 16 bits) sharing one alu16.
// Optional macro EARLY_EXIT_EN: finish as soon as no multiplier bits remain above the current one.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int unsigned ITER = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] product,
    output logic          zr,
    output logic          ng
);

    logic [1:0]    state, state_nxt;
    logic [DW-1:0] acc, mcand, mplr;
    logic [CW-1:0] cnt;
    logic          acc_zr, acc_ng;
    logic          last_c;

    logic [DW-1:0] alu_x, alu_y, alu_res;
    alu_ctl_t      alu_ctl;
    logic          alu_zr, alu_ng;

    alu16 u_alu (
        .x     (alu_x),
        .y     (alu_y),
        .ctl   (alu_ctl),
        .res_c (alu_res),
        .zr_c  (alu_zr),
        .ng_c  (alu_ng)
    );

`ifdef EARLY_EXIT_EN
    always_comb begin
        last_c = (cnt == CW'(ITER - 1)) || (((mplr >> cnt) >> 1) == '0);
    end
`else
    always_comb begin
        last_c = (cnt == CW'(ITER - 1));
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and ALU steering
    always_comb begin
        state_nxt = state;
        alu_ctl   = alu_ctl_t'(OP_ZERO);
        alu_x     = acc;
        alu_y     = mcand;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                alu_ctl   = mplr[cnt] ? alu_ctl_t'(OP_ADD) : alu_ctl_t'(OP_X);
                state_nxt = S_DBL;
            end
            S_DBL: begin
                alu_x     = mcand;
                alu_ctl   = alu_ctl_t'(OP_ADD);
                state_nxt = last_c ? S_DONE : S_ADD;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            zr      <= 1'b1;
            ng      <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            cnt     <= '0;
            acc_zr  <= 1'b1;
            acc_ng  <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= a;
                        mplr  <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                S_ADD: begin
                    acc    <= alu_res;
                    acc_zr <= alu_zr;
                    acc_ng <= alu_ng;
                end
                S_DBL: begin
                    mcand <= alu_res;
                    // Result publishes on the edge that enters DONE
                    if (last_c) begin
                        product <= acc;
                        zr      <= acc_zr;
                        ng      <= acc_ng;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed cases plus random operands against an arithmetic model.
module tb_mul_seq;

    localparam int unsigned ITER = 16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        zr;
    logic        ng;

    int n_cmp;
    int n_bad;

    mul_seq #(.ITER(ITER)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zr      (zr),
        .ng      (ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_product(input logic [15:0] ma, input logic [15:0] mb);
        longint unsigned m;
        longint unsigned p;
        m = (ITER >= 16) ? 64'hFFFF : ((64'd1 << ITER) - 1);
        p = longint'(ma) * (longint'(mb) & m);
        return 16'(p & 64'hFFFF);
    endfunction

    function automatic int model_latency(input logic [15:0] mb);
        int hi;
`ifdef EARLY_EXIT_EN
        hi = -1;
        for (int i = 0; i < int'(ITER); i++) begin
            if (mb[i]) hi = i;
        end
        return (hi < 0) ? 2 : 2 * (hi + 1);
`else
        hi = mb[0];
        return 2 * int'(ITER) + 0 * hi;
`endif
    endfunction

    // One operation; while busy, start/a/b are scrambled (or start held with 5,5) to prove they are ignored
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input bit hold_start);
        int          edges;
        bit          got;
        logic [15:0] exp_p;
        exp_p = model_product(ia, ib);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 200) begin
            if (hold_start) begin
                start = 1'b1;
                a     = 16'd5;
                b     = 16'd5;
            end else begin
                start = 1'($urandom_range(0, 1));
                a     = 16'($urandom);
                b     = 16'($urandom);
            end
            @(posedge clk);
            #1;
            edges++;
            if (done) got = 1'b1;
            else if (!busy) begin
                check("busy_during_op", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(edges), 32'(model_latency(ib)));
            check("product", 32'(product), 32'(exp_p));
            check("zr", 32'(zr), 32'(exp_p == 16'd0));
            check("ng", 32'(ng), 32'(exp_p[15]));
            check("busy_in_done", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_after_done", 32'(busy), 32'd0);
            check("product_held", 32'(product), 32'(exp_p));
            // Stay idle a cycle to confirm no queued second start produces another done
            @(posedge clk);
            #1;
            check("no_extra_done", 32'(done), 32'd0);
            check("no_queued_start", 32'(busy), 32'd0);
        end
    endtask

    task automatic reset_mid_op(input logic [15:0] ia, input logic [15:0] ib);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) check("early_done_before_rst", 32'(done), 32'd0);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_zr", 32'(zr), 32'd1);
        check("rst_ng", 32'(ng), 32'd0);
        for (int i = 0; i < 2 * int'(ITER) + 2; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) check("post_rst_quiet", 32'({busy, done}), 32'd0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = 16'd0;
        b     = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_zr", 32'(zr), 32'd1);
        check("reset_ng", 32'(ng), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(16'd100, 16'd3, 1'b0);
        run_op(16'hFFFF, 16'd3, 1'b0);
        run_op(16'd256, 16'd256, 1'b0);
        run_op(16'd1234, 16'd0, 1'b0);
        run_op(16'd7, 16'd9, 1'b1);
        run_op(16'hFFFF, 16'hFFFF, 1'b0);
        run_op(16'h8000, 16'd1, 1'b0);
        run_op(16'd3, 16'h8000, 1'b0);

        reset_mid_op(16'd1000, 16'd999);
        run_op(16'd12, 16'd11, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), 16'($urandom >> ($urandom_range(0, 15) + 16)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
